// File: rtl/lzx_hc138_grant_seq.sv
// ============================================================================
// Module   : lzx_hc138_grant_seq
// Brief    : Decodes an active-low 8:3 encoder code into a held, acknowledged,
//            timeout-guarded active-low one-hot grant with a post-release gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzx_hc138_grant_seq #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int HOLD    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] din_n,
    input  logic       GS_n,
    input  logic       EO_n,
    input  logic       G1,
    input  logic       G2A_n,
    input  logic       G2B_n,
    input  logic       ack,
    input  logic       err_clr,
    output logic [7:0] y_n,
    output logic       busy,
    output logic [2:0] grant_idx,
    output logic       timeout_err,
    output logic       no_req
);

    if (TIMEOUT < 1 || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_timeout
        $error("lzx_hc138_grant_seq: TIMEOUT out of range for CNT_W");
    end
    if (HOLD < 0 || HOLD > (2**CNT_W) - 1) begin : g_bad_hold
        $error("lzx_hc138_grant_seq: HOLD out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);
    // Unused when HOLD is 0: the hold-off state is never entered then.
    localparam logic [CNT_W-1:0] c_hold_last    = CNT_W'(HOLD - 1);
    localparam state_t           c_release_st   = (HOLD == 0) ? ST_IDLE : ST_HOLDOFF;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]       r_y_n, w_y_n_nxt;
    logic [2:0]       r_grant_idx, w_grant_idx_nxt;
    logic             r_busy;
    logic             r_timeout_err, w_timeout_err_nxt;
    logic             r_no_req, w_no_req_nxt;
    logic             w_set_err;
    logic             w_en;
    logic             w_req;
    logic [2:0]       w_idx;

    assign w_en  = G1 & ~G2A_n & ~G2B_n;
    // GS_n and EO_n both low is an illegal encoder state and never grants.
    assign w_req = w_en & ~GS_n & EO_n;
    assign w_idx = ~din_n;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_y_n_nxt       = r_y_n;
        w_grant_idx_nxt = r_grant_idx;
        w_no_req_nxt    = 1'b0;
        w_set_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_no_req_nxt = w_en & ~EO_n & GS_n;
                if (w_req) begin
                    w_grant_idx_nxt = w_idx;
                    w_y_n_nxt       = ~(8'h01 << w_idx);
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Losing enable beats ack and timeout and skips the hold-off gap.
                if (!w_en) begin
                    w_y_n_nxt   = 8'hFF;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (ack) begin
                    w_y_n_nxt   = 8'hFF;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_release_st;
                end else if (r_cnt == c_timeout_last) begin
                    w_y_n_nxt   = 8'hFF;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_release_st;
                    w_set_err   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt == c_hold_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_y_n_nxt   = 8'hFF;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_set_err)
            w_timeout_err_nxt = 1'b1;
        else if (err_clr)
            w_timeout_err_nxt = 1'b0;
        else
            w_timeout_err_nxt = r_timeout_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_y_n         <= 8'hFF;
            r_grant_idx   <= 3'd0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_no_req      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_y_n         <= w_y_n_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_timeout_err <= w_timeout_err_nxt;
            r_no_req      <= w_no_req_nxt;
        end
    end

    assign y_n         = r_y_n;
    assign busy        = r_busy;
    assign grant_idx   = r_grant_idx;
    assign timeout_err = r_timeout_err;
    assign no_req      = r_no_req;

endmodule

`default_nettype wire
